// File: rtl/wall_spawner.sv
// wall_spawner: draws candidate wall positions from the LFSR pair, grid-aligns
// them, rejects out-of-bounds or colliding candidates (head, food, placed walls)
// and commits accepted positions into a slot table read by renderer/collision.
// Optional build macro: WALL_HEAD_ZONE_EN (reject candidates near the head).
//
// state  | meaning
// -------+--------------------------------------------------------------
// IDLE   | waiting for spawn_req
// DRAW   | strobe rnd_en, capture aligned candidate at the edge
// CHECK  | validate candidate; retry, give up, or accept
// COMMIT | write candidate into slot[wall_count]
// DONE   | one-cycle done pulse
// FAIL   | one-cycle fail pulse, table unchanged
module wall_spawner #(
    parameter int NUM_WALLS = 8,
    parameter int X_MAX     = 640,
    parameter int Y_MAX     = 480,
    parameter int GRID_LOG2 = 4,
    parameter int MAX_TRIES = 15,
    parameter int HEAD_ZONE = 32
) (
    input  logic        pixel_clk,
    input  logic        reset,
    input  logic        spawn_req,
    input  logic        clear,
    input  logic [10:0] rnd_x,
    input  logic [10:0] rnd_y,
    output logic        rnd_en,
    input  logic [10:0] head_x,
    input  logic [10:0] head_y,
    input  logic [10:0] food_x,
    input  logic [10:0] food_y,
    input  logic [3:0]  rd_idx,
    output logic [10:0] rd_x,
    output logic [10:0] rd_y,
    output logic        rd_valid,
    output logic [4:0]  wall_count,
    output logic        busy,
    output logic        done,
    output logic        fail
);

    localparam logic [10:0] GRID_MASK = 11'h7FF << GRID_LOG2;

    typedef enum logic [2:0] {IDLE, DRAW, CHECK, COMMIT, DONE_S, FAIL_S} state_t;

    state_t      state, state_nxt;
    logic [7:0]  tries;
    logic [7:0]  tries_inc;
    logic [10:0] cand_x, cand_y;
    logic [10:0] slot_x [NUM_WALLS];
    logic [10:0] slot_y [NUM_WALLS];
    logic        hit_slot;
    logic        in_zone;
    logic        cand_ok;
    logic        table_full;

    assign tries_inc  = tries + 8'd1;
    assign table_full = (wall_count >= 5'(NUM_WALLS));

`ifdef WALL_HEAD_ZONE_EN
    logic [11:0] dist_x, dist_y;

    // Absolute distance to the head, computed on 12 bits so no wrap occurs.
    always_comb begin
        dist_x = (cand_x >= head_x) ? ({1'b0, cand_x} - {1'b0, head_x})
                                    : ({1'b0, head_x} - {1'b0, cand_x});
        dist_y = (cand_y >= head_y) ? ({1'b0, cand_y} - {1'b0, head_y})
                                    : ({1'b0, head_y} - {1'b0, cand_y});
        in_zone = (dist_x < 12'(HEAD_ZONE)) && (dist_y < 12'(HEAD_ZONE));
    end
`else
    logic [11:0] unused_head_zone;
    assign unused_head_zone = 12'(HEAD_ZONE);
    assign in_zone = 1'b0;
`endif

    // Candidate validation; only filled slots take part in the overlap test.
    always_comb begin
        hit_slot = 1'b0;
        for (int i = 0; i < NUM_WALLS; i++) begin
            if ((5'(i) < wall_count) && (slot_x[i] == cand_x) && (slot_y[i] == cand_y))
                hit_slot = 1'b1;
        end
        cand_ok = (cand_x != 11'd0) && (cand_y != 11'd0)
               && ({1'b0, cand_x} < 12'(X_MAX)) && ({1'b0, cand_y} < 12'(Y_MAX))
               && !((cand_x == (head_x & GRID_MASK)) && (cand_y == (head_y & GRID_MASK)))
               && !((cand_x == (food_x & GRID_MASK)) && (cand_y == (food_y & GRID_MASK)))
               && !hit_slot && !in_zone;
    end

    // State register.
    always_ff @(posedge pixel_clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state decode and Moore outputs; clear overrides everything.
    always_comb begin
        state_nxt = state;
        rnd_en    = 1'b0;
        done      = 1'b0;
        fail      = 1'b0;
        busy      = (state != IDLE);
        case (state)
            IDLE:    if (spawn_req) state_nxt = table_full ? FAIL_S : DRAW;
            DRAW: begin
                rnd_en    = 1'b1;
                state_nxt = CHECK;
            end
            CHECK: begin
                if (cand_ok)                         state_nxt = COMMIT;
                else if (tries_inc == 8'(MAX_TRIES)) state_nxt = FAIL_S;
                else                                 state_nxt = DRAW;
            end
            COMMIT:  state_nxt = DONE_S;
            DONE_S: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            FAIL_S: begin
                fail      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        if (clear) state_nxt = IDLE;
    end

    // Datapath: retry counter, candidate capture and slot table.
    always_ff @(posedge pixel_clk or negedge reset) begin
        if (!reset) begin
            tries      <= 8'd0;
            cand_x     <= 11'd0;
            cand_y     <= 11'd0;
            wall_count <= 5'd0;
            for (int i = 0; i < NUM_WALLS; i++) begin
                slot_x[i] <= 11'd0;
                slot_y[i] <= 11'd0;
            end
        end else if (clear) begin
            tries      <= 8'd0;
            wall_count <= 5'd0;
            for (int i = 0; i < NUM_WALLS; i++) begin
                slot_x[i] <= 11'd0;
                slot_y[i] <= 11'd0;
            end
        end else begin
            case (state)
                IDLE:  tries <= 8'd0;
                DRAW: begin
                    cand_x <= rnd_x & GRID_MASK;
                    cand_y <= rnd_y & GRID_MASK;
                end
                CHECK: if (!cand_ok) tries <= tries_inc;
                COMMIT: begin
                    for (int i = 0; i < NUM_WALLS; i++) begin
                        if (5'(i) == wall_count) begin
                            slot_x[i] <= cand_x;
                            slot_y[i] <= cand_y;
                        end
                    end
                    wall_count <= wall_count + 5'd1;
                end
                default: ;
            endcase
        end
    end

    // Combinational read port; unfilled or out-of-range indices read as empty.
    always_comb begin
        rd_valid = ({1'b0, rd_idx} < wall_count) && ({1'b0, rd_idx} < 5'(NUM_WALLS));
        rd_x     = 11'd0;
        rd_y     = 11'd0;
        for (int i = 0; i < NUM_WALLS; i++) begin
            if (rd_valid && (4'(i) == rd_idx)) begin
                rd_x = slot_x[i];
                rd_y = slot_y[i];
            end
        end
    end

endmodule

// File: tb/tb_wall_spawner.sv
// Testbench for wall_spawner: directed requests push expected responses into a
// scoreboard; a monitor pops and compares on every done/fail pulse.
module tb_wall_spawner;

    logic        pixel_clk = 1'b0;
    logic        reset     = 1'b0;
    logic        spawn_req = 1'b0;
    logic        clear     = 1'b0;
    logic [10:0] rnd_x = 11'd0, rnd_y = 11'd0;
    logic [10:0] head_x = 11'd320, head_y = 11'd240;
    logic [10:0] food_x = 11'd0, food_y = 11'd0;
    logic [3:0]  rd_idx = 4'd0;
    logic        rnd_en, rd_valid, busy, done, fail;
    logic [10:0] rd_x, rd_y;
    logic [4:0]  wall_count;

    wall_spawner dut (
        .pixel_clk(pixel_clk), .reset(reset), .spawn_req(spawn_req), .clear(clear),
        .rnd_x(rnd_x), .rnd_y(rnd_y), .rnd_en(rnd_en),
        .head_x(head_x), .head_y(head_y), .food_x(food_x), .food_y(food_y),
        .rd_idx(rd_idx), .rd_x(rd_x), .rd_y(rd_y), .rd_valid(rd_valid),
        .wall_count(wall_count), .busy(busy), .done(done), .fail(fail)
    );

    always #5 pixel_clk = ~pixel_clk;

    typedef struct {
        bit is_fail;
        int lat;
        int strobes;
        int wc;
    } exp_t;

    exp_t        sb[$];
    logic [10:0] dx_q[$], dy_q[$];
    int checks = 0, errors = 0;
    int cyc = 0, req_cyc = 0, n_rnd = 0, n_busy = 0;
    bit draw_seen = 1'b0;

    always @(posedge pixel_clk) cyc <= cyc + 1;

    function automatic void chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, req, $time);
        end
    endfunction

    // Monitor: counts strobes/busy cycles and scores every done/fail pulse.
    always @(negedge pixel_clk) begin
        exp_t e;
        draw_seen = rnd_en;
        if (rnd_en) n_rnd++;
        if (busy)   n_busy++;
        if (done || fail) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_pulse done=%0d fail=%0d required none", done, fail);
            end else begin
                e = sb.pop_front();
                chk("done_pulse", int'(done), int'(!e.is_fail));
                chk("fail_pulse", int'(fail), int'(e.is_fail));
                chk("latency", cyc - req_cyc, e.lat);
                chk("rnd_strobes", n_rnd, e.strobes);
                chk("busy_cycles", n_busy, e.lat);
                chk("wall_count", int'(wall_count), e.wc);
            end
        end
    end

    // LFSR stand-in: after each draw edge, present the next queued value.
    initial forever begin
        @(posedge pixel_clk);
        #1;
        if (draw_seen && dx_q.size() > 1) begin
            void'(dx_q.pop_front());
            void'(dy_q.pop_front());
            rnd_x = dx_q[0];
            rnd_y = dy_q[0];
        end
    end

    task automatic load(input logic [10:0] x, input logic [10:0] y);
        dx_q.push_back(x);
        dy_q.push_back(y);
    endtask

    task automatic unload();
        dx_q.delete();
        dy_q.delete();
    endtask

    task automatic request(input bit is_fail, input int lat, input int strobes, input int wc);
        exp_t e;
        int   budget;
        @(posedge pixel_clk);
        #1;
        e.is_fail = is_fail; e.lat = lat; e.strobes = strobes; e.wc = wc;
        sb.push_back(e);
        n_rnd = 0; n_busy = 0; req_cyc = cyc;
        rnd_x = dx_q[0];
        rnd_y = dy_q[0];
        spawn_req = 1'b1;
        @(posedge pixel_clk);
        #1;
        spawn_req = 1'b0;
        budget = 0;
        while (sb.size() != 0 && budget < 100) begin
            @(posedge pixel_clk);
            #1;
            budget++;
        end
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL response_timeout pending=%0d required 0", sb.size());
            sb.delete();
        end
        @(posedge pixel_clk);
        #1;
        unload();
    endtask

    task automatic rd_chk(input int idx, input int x, input int y, input int v);
        @(posedge pixel_clk);
        #1;
        rd_idx = 4'(idx);
        #1;
        chk("rd_x", int'(rd_x), x);
        chk("rd_y", int'(rd_y), y);
        chk("rd_valid", int'(rd_valid), v);
    endtask

    initial begin
        repeat (2) @(posedge pixel_clk);
        #1;
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_fail", int'(fail), 0);
        chk("rst_rnd_en", int'(rnd_en), 0);
        chk("rst_wall_count", int'(wall_count), 0);
        chk("rst_rd_valid", int'(rd_valid), 0);
        reset = 1'b1;

        // First-try success: (100,50) aligns to (96,48).
        load(11'd100, 11'd50);
        request(1'b0, 4, 1, 1);
        rd_chk(0, 96, 48, 1);

        // Every draw aligns to zero: 15 strobes, then fail.
        load(11'd5, 11'd3);
        request(1'b1, 31, 15, 1);

        // Out-of-bounds first draw, then success.
        load(11'd700, 11'd100);
        load(11'd200, 11'd100);
        request(1'b0, 6, 2, 2);
        rd_chk(1, 192, 96, 1);

        // Rejections for slot overlap, head, food; then success.
        food_x = 11'd40; food_y = 11'd40;
        load(11'd100, 11'd50);
        load(11'd325, 11'd245);
        load(11'd35, 11'd33);
        load(11'd250, 11'd400);
        request(1'b0, 10, 4, 3);
        rd_chk(2, 240, 400, 1);
        rd_chk(3, 0, 0, 0);

        // Clear while in CHECK with three walls placed.
        load(11'd500, 11'd400);
        @(posedge pixel_clk);
        #1;
        n_rnd = 0;
        rnd_x = dx_q[0]; rnd_y = dy_q[0];
        spawn_req = 1'b1;
        @(posedge pixel_clk);
        #1;
        spawn_req = 1'b0;
        @(posedge pixel_clk);
        #1;
        chk("busy_in_check", int'(busy), 1);
        clear = 1'b1;
        @(posedge pixel_clk);
        #1;
        clear = 1'b0;
        chk("clear_busy", int'(busy), 0);
        chk("clear_wall_count", int'(wall_count), 0);
        chk("clear_strobes", n_rnd, 1);
        for (int i = 0; i < 16; i++) rd_chk(i, 0, 0, 0);
        unload();

        // clear and spawn_req together: request is dropped.
        load(11'd500, 11'd400);
        @(posedge pixel_clk);
        #1;
        n_rnd = 0;
        spawn_req = 1'b1; clear = 1'b1;
        @(posedge pixel_clk);
        #1;
        spawn_req = 1'b0; clear = 1'b0;
        chk("clear_spawn_busy", int'(busy), 0);
        repeat (3) @(posedge pixel_clk);
        #1;
        chk("clear_spawn_strobes", n_rnd, 0);
        unload();

        // Draw next to the head, then a clear spot.
        load(11'd336, 11'd256);
        load(11'd400, 11'd300);
`ifdef WALL_HEAD_ZONE_EN
        request(1'b0, 6, 2, 1);
        rd_chk(0, 400, 288, 1);
`else
        request(1'b0, 4, 1, 1);
        rd_chk(0, 336, 256, 1);
`endif

        // Fill the remaining seven slots.
        for (int i = 0; i < 7; i++) begin
            load(11'(32 * (i + 1)), 11'(208 + 16 * i));
            request(1'b0, 4, 1, i + 2);
        end
        rd_chk(7, 224, 304, 1);
        rd_chk(8, 0, 0, 0);

        // Full table: immediate fail, no draw, busy exactly one cycle.
        load(11'd500, 11'd400);
        request(1'b1, 1, 0, 8);
        rd_chk(5, 160, 272, 1);

        repeat (3) @(posedge pixel_clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/wall_spawner.md
Name: wall_spawner

Overview:
- Sequences obstacle placement for the play field.
- On request, draws candidate (x,y) positions from the shared LFSR pair, grid-aligns them and checks them against screen bounds, snake head, food and walls already placed.
- Commits accepted positions into a slot table that the renderer and collision logic read.
- Retries rejected candidates up to a bounded count. Sits between game-control logic and the LFSR sources.

Parameters:
- NUM_WALLS, 8, number of wall slots (1..16).
- X_MAX, 640, exclusive upper bound for x.
- Y_MAX, 480, exclusive upper bound for y.
- GRID_LOG2, 4, candidates aligned to 2^GRID_LOG2-pixel grid.
- MAX_TRIES, 15, draws per request before failure (1..255).
- HEAD_ZONE, 32, exclusion half-width around head (used only with the optional feature).

Ports:
- pixel_clk  in  1  clock; all state on rising edge.
- reset  in  1  asynchronous, active-low reset.
- spawn_req  in  1  place one wall; sampled only in IDLE.
- clear  in  1  empty slot table, abort any operation.
- rnd_x  in  11  LFSR x output.
- rnd_y  in  11  LFSR y output.
- rnd_en  out  1  advance LFSRs; one-cycle strobe per draw.
- head_x, head_y  in  11 each  current snake head.
- food_x, food_y  in  11 each  current food position.
- rd_idx  in  4  slot read index.
- rd_x, rd_y  out  11 each  slot contents; combinational from rd_idx.
- rd_valid  out  1  rd_idx < wall_count.
- wall_count  out  5  slots filled.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle pulse on commit.
- fail  out  1  one-cycle pulse when a request is rejected.

Behaviour:
- Reset (reset=0): state IDLE; all slots (0,0); wall_count=0; tries=0; rnd_en, done, fail, busy = 0.
- Position (0,0) means "empty". A candidate aligning to x=0 or y=0 is invalid.
- States: IDLE, DRAW, CHECK, COMMIT, DONE, FAIL.
- IDLE: spawn_req=1 with wall_count<NUM_WALLS -> DRAW, tries=0. spawn_req=1 with wall_count==NUM_WALLS -> FAIL, no draw.
- DRAW: rnd_en=1 for this cycle only. At the edge, cand_x={rnd_x[10:GRID_LOG2],0s} and cand_y likewise are captured. -> CHECK.
- CHECK: candidate is valid iff all hold:
  - cand_x!=0 and cand_y!=0;
  - cand_x<X_MAX and cand_y<Y_MAX;
  - cand != head and cand != food, compared after aligning head/food the same way;
  - cand != any filled slot.
- CHECK valid -> COMMIT. Invalid -> tries+1; if tries+1==MAX_TRIES -> FAIL, else -> DRAW.
- COMMIT: slot[wall_count]=cand; wall_count+1. -> DONE.
- DONE: done=1 for one cycle. -> IDLE.
- FAIL: fail=1 for one cycle; table unchanged. -> IDLE.
- Latency: first-try success gives done high 4 cycles after the accepting edge. Each retry adds 2 cycles.
- clear=1: synchronous, highest priority in every state. Next edge: IDLE, all slots (0,0), wall_count=0, no done/fail pulse.
- clear and spawn_req together: clear wins; request dropped.
- spawn_req while busy is ignored and not queued.
- Read port: rd_idx >= wall_count or >= NUM_WALLS -> rd_x=rd_y=0, rd_valid=0.
- Inputs head/food are sampled in the CHECK cycle only.
- Asserting reset mid-operation immediately forces reset values; no pulse is emitted.

Optional Feature:
- Macro WALL_HEAD_ZONE_EN.
- Defined: CHECK additionally rejects a candidate if |cand_x-head_x|<HEAD_ZONE and |cand_y-head_y|<HEAD_ZONE. Use unsigned-safe 12-bit differences.
- Undefined: only exact head equality is rejected; HEAD_ZONE unused.

Test Plan:
- Reset released; rnd=(100,50); head=(320,240); food=(0,0); pulse spawn_req -> rnd_en one cycle, done 4 cycles later; slot0=(96,48); wall_count=1.
- rnd held at (5,3) (aligns to 0) with MAX_TRIES=15 -> 15 rnd_en strobes, then fail pulse; wall_count unchanged; done never asserted.
- Fill 8 slots with distinct rnd values, then spawn_req -> fail on the cycle after acceptance, rnd_en never asserted, busy high exactly 1 cycle.
- First draw (700,100) out of bounds, second (200,100) -> two rnd_en strobes, done at cycle 6, slot=(192,96).
- Assert clear during CHECK with 3 walls placed -> next cycle IDLE, wall_count=0, rd_valid=0 for all rd_idx, no done/fail.
- WALL_HEAD_ZONE_EN defined, head=(320,240), draw (336,256) then (400,300) -> first rejected, slot=(400,288).
